// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of a slow asynchronous input over a fixed
// gate window of clk cycles and publishes one registered count per window.
// Windows run back-to-back while en is high, so every clk cycle belongs to
// exactly one window. The count saturates instead of wrapping. ovf reports
// that at least one rising edge was lost because the counter was already
// at its maximum.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no window open; gcnt/ecnt held at 0; waits for en
// GATE  | window open; gcnt counts cycles, ecnt counts detected rises

module freq_meter #(
  parameter int GATE_CYCLES = 50,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy
);

  // GATE_CYCLES >= 2, so this is always at least 1 bit and holds GATE_CYCLES-1.
  localparam int                GCNT_W    = $clog2(GATE_CYCLES);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ECNT_MAX  = '1;

  typedef enum logic {
    IDLE,
    GATE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s_sync;
  logic                   rise;
  logic [GCNT_W-1:0]      gcnt;
  logic [CNT_W-1:0]       ecnt;
  logic                   sat;
  logic [CNT_W-1:0]       ecnt_inc;
  logic                   sat_inc;
  logic                   last_cycle;

  // Synchronizer chain and previous-value flop; they run in every state so
  // an edge arriving just before a window opens is still seen correctly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= s_sync;
    end
  end

  assign s_sync     = sync_q[SYNC_STAGES-1];
  assign rise       = s_sync & ~prev_q;
  assign last_cycle = (gcnt == GCNT_LAST);

  // Edge count including this cycle's rise; the final window cycle publishes
  // this value so a rise detected on the last cycle is not lost.
  always_comb begin
    ecnt_inc = ecnt;
    sat_inc  = sat;
    if (rise) begin
      if (ecnt == ECNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        ecnt_inc = ecnt + 1'b1;
      end
    end
  end

  // Window sequencing, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gcnt       <= '0;
      ecnt       <= '0;
      sat        <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          gcnt <= '0;
          ecnt <= '0;
          sat  <= 1'b0;
          if (en) begin
            state <= GATE;
            busy  <= 1'b1;
          end
        end
        GATE: begin
          if (last_cycle) begin
            // The window completes even if en falls on its last cycle.
            freq       <= ecnt_inc;
            ovf        <= sat_inc;
            freq_valid <= 1'b1;
            gcnt       <= '0;
            ecnt       <= '0;
            sat        <= 1'b0;
            if (!en) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (!en) begin
            // Partial window: discard counts, leave published result alone.
            state <= IDLE;
            busy  <= 1'b0;
            gcnt  <= '0;
            ecnt  <= '0;
            sat   <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
            ecnt <= ecnt_inc;
            sat  <= sat_inc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          gcnt  <= '0;
          ecnt  <= '0;
          sat   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the frequency of a slow, asynchronous square-wave input. It does this by counting the input's rising edges over a fixed gate window of system-clock cycles. It is the measuring counterpart of the team's clock divider: the divider turns the fast clock into a slow toggle, and this block turns a slow toggle back into a number. It sits between an external or divided signal and the display/readout logic, and publishes one registered count per window.

Parameters:
GATE_CYCLES, 50, gate window length in clk cycles (must be ≥ 2)
CNT_W, 16, width of the edge counter and the result
SYNC_STAGES, 2, number of synchronizer flops on sig_in (must be ≥ 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  measurement enable; windows run back-to-back while high
sig_in  input  1  asynchronous signal to measure
freq  output  CNT_W  rising-edge count of the last completed window (registered)
freq_valid  output  1  one-cycle pulse when freq is updated
ovf  output  1  last completed window saturated; updated together with freq
busy  output  1  high while a gate window is open

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is sampled on the clk rising edge only.
  - Reset values: freq=0, freq_valid=0, ovf=0, busy=0. Synchronizer chain=0, edge-detect register=0, FSM=IDLE, gate counter gcnt=0, edge counter ecnt=0.
- Input conditioning:
  - sig_in passes through SYNC_STAGES flops, giving s_sync.
  - A prev flop holds the last s_sync.
  - rise = s_sync & ~prev.
  - The synchronizer and prev flop update every cycle regardless of state or en.
- FSM states: IDLE, GATE.
- IDLE:
  - busy=0; gcnt and ecnt are held at 0.
  - If en=1, go to GATE on the next cycle with gcnt=0 and ecnt=0.
- GATE:
  - busy=1.
  - Each cycle, gcnt increments.
  - If rise=1, ecnt increments, saturating at 2^CNT_W-1 and setting an internal sat flag.
  - A rise in the first cycle (gcnt=0) counts.
  - A rise in the last cycle (gcnt=GATE_CYCLES-1) counts.
- Window end (cycle with gcnt=GATE_CYCLES-1), on the next edge:
  - freq <= final count, including a rise in this cycle (saturated).
  - ovf <= sat, counting the final increment.
  - freq_valid <= 1 for exactly one cycle.
  - If en=1: stay in GATE with gcnt=0, ecnt=0, sat=0. There is no gap cycle, and every clk cycle belongs to exactly one window.
  - If en=0: go to IDLE.
- en dropped before the last window cycle:
  - The window is aborted: next cycle is IDLE, counts are discarded.
  - freq, ovf and freq_valid do not change.
- Output hold: freq and ovf hold their value between updates and are never cleared except by rst.
- Reset during a window:
  - Aborts immediately; all state goes to its reset value; no freq_valid pulse.
  - After release, if en=1 the first window starts one cycle after the first non-reset cycle (IDLE to GATE).
- Latency:
  - From a sig_in edge to detection: SYNC_STAGES+1 cycles.
  - An edge whose detection lands after the window end counts in the next window.
- Arithmetic:
  - Counters are unsigned.
  - The gcnt width is wide enough to hold GATE_CYCLES-1.
  - ecnt never wraps.

Test Plan:
- Period-10 square wave (5 high/5 low), en=1, defaults → after every window, freq=5, ovf=0, freq_valid pulses exactly every 50 cycles, busy stays 1.
- sig_in held constant at 0, then constant at 1 → freq=0 each window; the 0→1 step yields freq=1 in exactly one window only.
- sig_in toggling every cycle (period 2) → freq=25; with CNT_W=4 → freq=15, ovf=1; next window with period 10 → freq=5, ovf=0.
- en dropped at gcnt=30 → no freq_valid, freq keeps its previous value, busy=0 next cycle; re-raise en → the window starts one cycle later and a full 50-cycle window reports the correct count.
- rst asserted for 3 cycles mid-window → all outputs 0 during reset, no valid pulse; after release, with a period-10 input, the first result is freq=5.
- Edge exactly at the window boundary (detected rise at gcnt=49) → counted in the ending window; a rise detected at gcnt=0 of the next window → counted in that window.
